i2c_target_regs: RTL

//   I2C target (slave) that sits on the same SCL/SDA bus as the I2C master and answers its transactions.
//   It holds a 32-bit write register loaded by master write transactions.
//   It returns a 32-bit read word to master read transactions.
//   The bus is oversampled on the system clock and driven open-drain: SDA is only ever pulled low or released.

---
 rtl/i2c_target_regs.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a 32-bit write register and a 32-bit read word.
// Bus is oversampled on clk; SDA is open-drain (pulled low or released).
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  input  logic [31:0] reg_din,
  output logic [31:0] reg_dout,
  output logic        wr_done,
  output logic        rd_done,
  output logic        busy,
  output logic [1:0]  byte_idx
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WR_ACK,
    READ,
    RD_ACK,
    IGNORE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_s;
  logic sda_s;
  logic scl_q;
  logic sda_q;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  logic        sda_oe;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_byte;
  logic [7:0]  cur_byte;
  logic [31:0] rd_word;
  logic        rw;
  logic        ack_on;
  logic        wr_any;
  logic        rd_any;

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  // Idle bus is high, so the synchronisers reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte  = {shreg[6:0], sda_s};

  always_comb begin
    cur_byte = rd_word[31:24];
    unique case (byte_idx)
      2'd0: cur_byte = rd_word[31:24];
      2'd1: cur_byte = rd_word[23:16];
      2'd2: cur_byte = rd_word[15:8];
      2'd3: cur_byte = rd_word[7:0];
      default: cur_byte = rd_word[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rd_word  <= '0;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
      wr_any   <= 1'b0;
      rd_any   <= 1'b0;
      reg_dout <= '0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      busy     <= 1'b0;
      byte_idx <= '0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (start || stop) begin
        wr_done <= wr_any;
        rd_done <= rd_any;
        wr_any  <= 1'b0;
        rd_any  <= 1'b0;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        bit_cnt <= '0;
        state   <= start ? ADDR : IDLE;
      end else begin
        unique case (state)
          IDLE: sda_oe <= 1'b0;
          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on   <= 1'b0;
                byte_idx <= '0;
                bit_cnt  <= '0;
                if (rw) begin
                  rd_word <= reg_din;
                  shreg   <= reg_din[31:24];
                  sda_oe  <= ~reg_din[31];
                  state   <= READ;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WRITE;
                end
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                unique case (byte_idx)
                  2'd0: reg_dout[31:24] <= rx_byte;
                  2'd1: reg_dout[23:16] <= rx_byte;
                  2'd2: reg_dout[15:8]  <= rx_byte;
                  2'd3: reg_dout[7:0]   <= rx_byte;
                  default: reg_dout[31:24] <= rx_byte;
                endcase
                byte_idx <= byte_idx + 2'd1;
                wr_any   <= 1'b1;
                state    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WRITE;
              end
            end
          end
          // shreg[7] is on the bus; each fall advances to the next bit
          READ: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
                rd_any <= 1'b1;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shreg[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && !ack_on) begin
              if (sda_s) begin
                busy  <= 1'b0;
                state <= IGNORE;
              end else begin
                byte_idx <= byte_idx + 2'd1;
                ack_on   <= 1'b1;
              end
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              shreg   <= cur_byte;
              sda_oe  <= ~cur_byte[7];
              bit_cnt <= '0;
              state   <= READ;
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
